// File: rtl/ahb_uart_rx_if.sv
// ---------------------------------------------------------------------------
// ahb_uart_rx_if
// AHB-Lite slave-side signal bundle for the UART receiver.
//   HADDR  [31:0] address (only bit 2 decoded by the slave)
//   HSEL          slave select from the matrix decoder
//   HTRANS [1:0]  transfer type, bit 1 marks a valid transfer
//   HWRITE        1 = write, 0 = read
//   HWDATA [31:0] write data (data phase)
//   HRDATA [31:0] read data (data phase)
//   HREADY        always 1 (zero wait states)
//   HRESP         always 0 (OKAY)
// ---------------------------------------------------------------------------
interface ahb_uart_rx_if;
  logic [31:0] HADDR;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HSEL, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HSEL, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_uart_rx.sv
// ---------------------------------------------------------------------------
// ahb_uart_rx
// AHB-Lite slave UART receiver. Deserialises 8N1 frames from UART_RX into a
// receive FIFO; the CPU pops bytes through DATA (0x0) and polls / clears the
// sticky error flags through STATUS (0x4).
//   HCLK     bus clock, all logic on posedge
//   HRESETn  synchronous active-low reset
//   bus      AHB-Lite slave modport (HADDR/HSEL/HTRANS/HWRITE/HWDATA in,
//            HRDATA/HREADY/HRESP out)
//   UART_RX  asynchronous serial input, idle high
// STATUS layout: bit3 FERR, bit2 OVR, bit1 FULL, bit0 NOT_EMPTY.
// ---------------------------------------------------------------------------
module ahb_uart_rx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 3
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  ahb_uart_rx_if.slave bus,
  input  logic         UART_RX
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_t;

  // Line synchroniser
  logic [1:0]       r_sync;
  logic             w_rx_s;

  // Receive FSM
  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [2:0]       r_idx, w_idx_n;
  logic [7:0]       r_sh, w_sh_n;
  logic             w_push;
  logic             w_ferr_set;

  // FIFO and flags
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_ovr, r_ferr;
  logic               w_full, w_nempty;
  logic               w_pop, w_push_ok, w_ovr_set;

  // Bus
  logic               w_accept, w_rd_data, w_rd_stat;
  logic               r_wr_stat;
  logic               w_clr_ovr, w_clr_ferr;
  logic [31:0]        r_hrdata;
  logic               w_unused_bits;

  assign bus.HREADY = 1'b1;
  assign bus.HRESP  = 1'b0;
  assign bus.HRDATA = r_hrdata;

  assign w_unused_bits = &{1'b0, bus.HADDR[31:3], bus.HADDR[1:0], bus.HTRANS[0],
                           bus.HWDATA[31:4], bus.HWDATA[1:0]};

  // Stage: two-flop synchroniser, resets to the idle (high) line level
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], UART_RX};
  end
  assign w_rx_s = r_sync[1];

  // Stage: receive FSM state register
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
    end
  end

  always_ff @(posedge HCLK) begin
    r_sh <= w_sh_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_idx_n    = r_idx;
    w_sh_n     = r_sh;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_n = S_START;
          w_cnt_n   = CNT_HALF;
        end
      end
      S_START: begin
        // Half a bit later the line must still be low, otherwise it was a glitch
        if (r_cnt == '0) begin
          if (!w_rx_s) begin
            w_state_n = S_DATA;
            w_cnt_n   = CNT_FULL;
            w_idx_n   = 3'd0;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_sh_n  = {w_rx_s, r_sh[7:1]};
          w_cnt_n = CNT_FULL;
          if (r_idx == 3'd7) w_state_n = S_STOP;
          else               w_idx_n   = r_idx + 3'd1;
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (w_rx_s) begin
            w_push    = 1'b1;
            w_state_n = S_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_state_n  = S_WAIT_HI;
          end
        end else begin
          w_cnt_n = r_cnt - CNT_W'(1);
        end
      end
      S_WAIT_HI: begin
        // Hold off start detection until a break releases the line
        if (w_rx_s) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Stage: bus decode and FIFO control
  assign w_accept   = bus.HSEL & bus.HTRANS[1];
  assign w_rd_data  = w_accept & ~bus.HWRITE & ~bus.HADDR[2];
  assign w_rd_stat  = w_accept & ~bus.HWRITE &  bus.HADDR[2];
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nempty   = (r_count != '0);
  assign w_pop      = w_rd_data & w_nempty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_ovr_set  = w_push & w_full & ~w_pop;
  assign w_clr_ovr  = r_wr_stat & bus.HWDATA[2];
  assign w_clr_ferr = r_wr_stat & bus.HWDATA[3];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_wr_stat <= 1'b0;
    else          r_wr_stat <= w_accept & bus.HWRITE & bus.HADDR[2];
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_rd_data) begin
      r_hrdata <= w_nempty ? {24'b0, r_mem[r_rptr]} : 32'b0;
    end else if (w_rd_stat) begin
      r_hrdata <= {28'b0, r_ferr, r_ovr, w_full, w_nempty};
    end
  end

  // Sticky flags: a set on the same edge as a clear wins
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~w_clr_ovr);
      r_ferr <= w_ferr_set | (r_ferr & ~w_clr_ferr);
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)     r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_push_ok) r_mem[r_wptr] <= r_sh;
  end

endmodule

// File: tb/tb_ahb_uart_rx.sv
module tb_ahb_uart_rx;

  logic HCLK;
  logic HRESETn;
  logic UART_RX;
  int   errors = 0;
  int   checks = 0;

  ahb_uart_rx_if bus ();

  ahb_uart_rx #(
    .CLK_HZ (1_000_000),
    .BAUD   (100_000),
    .FIFO_AW(3)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus.slave),
    .UART_RX(UART_RX)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HADDR  = a;
    @(negedge HCLK);
    bus_idle();
    d = bus.HRDATA;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge HCLK);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HADDR  = a;
    @(negedge HCLK);
    bus_idle();
    bus.HWDATA = wd;
    @(negedge HCLK);
    bus.HWDATA = 32'h0;
  endtask

  // Called at a negedge; 10 clocks per bit, start bit, LSB first, stop bit
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RX = fr[i];
      repeat (10) @(negedge HCLK);
    end
    UART_RX = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    HRESETn    = 1'b0;
    UART_RX    = 1'b1;
    bus.HWDATA = 32'h0;
    bus_idle();
    repeat (3) @(negedge HCLK);
    checks++;
    if (bus.HRDATA !== 32'h0) begin
      $display("FAIL rst_hrdata: got %h expected %h", bus.HRDATA, 32'h0); errors++;
    end
    checks++;
    if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      $display("FAIL rst_ready_resp: got %b/%b expected 1/0", bus.HREADY, bus.HRESP); errors++;
    end
    HRESETn = 1'b1;
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL rst_status: got %h expected %h", d, 32'h0); errors++;
    end
    ahb_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL rst_data_empty: got %h expected %h", d, 32'h0); errors++;
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    @(negedge HCLK);
    send_frame(8'hA5, 1'b1);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h1) begin
      $display("FAIL t1_status_ne: got %h expected %h", d, 32'h1); errors++;
    end
    ahb_read(32'h0, d);
    checks++;
    if (d !== 32'h0000_00A5) begin
      $display("FAIL t1_data: got %h expected %h", d, 32'hA5); errors++;
    end
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t1_status_empty: got %h expected %h", d, 32'h0); errors++;
    end
    ahb_write(32'h0, 32'hFF);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t1_data_write_ignored: got %h expected %h", d, 32'h0); errors++;
    end
    checks++;
    if (bus.HREADY !== 1'b1 || bus.HRESP !== 1'b0) begin
      $display("FAIL t1_ready_resp: got %b/%b expected 1/0", bus.HREADY, bus.HRESP); errors++;
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge HCLK);
    UART_RX = 1'b0;
    repeat (5) @(negedge HCLK);
    UART_RX = 1'b1;
    repeat (30) @(negedge HCLK);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t2_glitch_status: got %h expected %h", d, 32'h0); errors++;
    end
    send_frame(8'hC3, 1'b1);
    ahb_read(32'h0, d);
    checks++;
    if (d !== 32'h0000_00C3) begin
      $display("FAIL t2_after_glitch_data: got %h expected %h", d, 32'hC3); errors++;
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    @(negedge HCLK);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h7) begin
      $display("FAIL t3_status_ovr_full: got %h expected %h", d, 32'h7); errors++;
    end
    for (int i = 1; i <= 8; i++) begin
      ahb_read(32'h0, d);
      checks++;
      if (d !== 32'(i)) begin
        $display("FAIL t3_data_%0d: got %h expected %h", i, d, 32'(i)); errors++;
      end
    end
    ahb_read(32'h0, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t3_data_empty: got %h expected %h", d, 32'h0); errors++;
    end
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h4) begin
      $display("FAIL t3_status_ovr_only: got %h expected %h", d, 32'h4); errors++;
    end
    ahb_write(32'h4, 32'h4);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t3_ovr_clear: got %h expected %h", d, 32'h0); errors++;
    end
  endtask

  task automatic test_frame_error();
    logic [31:0] d;
    @(negedge HCLK);
    send_frame(8'h3C, 1'b0);
    repeat (5) @(negedge HCLK);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h8) begin
      $display("FAIL t4_ferr_status: got %h expected %h", d, 32'h8); errors++;
    end
    ahb_write(32'h4, 32'h4);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h8) begin
      $display("FAIL t4_ferr_wrong_bit: got %h expected %h", d, 32'h8); errors++;
    end
    ahb_write(32'h4, 32'h8);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t4_ferr_clear: got %h expected %h", d, 32'h0); errors++;
    end
  endtask

  task automatic test_full_pop_same_edge();
    logic [31:0] d;
    logic [31:0] d0;
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h3) begin
      $display("FAIL t5_full_status: got %h expected %h", d, 32'h3); errors++;
    end
    // Stop bit of the 9th frame is sampled 98 edges after the start bit is driven;
    // the DATA read address phase lands on that same edge.
    fork
      send_frame(8'h09, 1'b1);
      begin
        repeat (96) @(negedge HCLK);
        ahb_read(32'h0, d0);
      end
    join
    checks++;
    if (d0 !== 32'h1) begin
      $display("FAIL t5_pop_on_push: got %h expected %h", d0, 32'h1); errors++;
    end
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h3) begin
      $display("FAIL t5_no_ovr_full: got %h expected %h", d, 32'h3); errors++;
    end
    for (int i = 2; i <= 9; i++) begin
      ahb_read(32'h0, d);
      checks++;
      if (d !== 32'(i)) begin
        $display("FAIL t5_order_%0d: got %h expected %h", i, d, 32'(i)); errors++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    do_reset();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h1) begin
      $display("FAIL t6_queued_status: got %h expected %h", d, 32'h1); errors++;
    end
    // 0x55 LSB first: start 0, then 1,0,1,0 ... abandon in the middle of bit 3
    UART_RX = 1'b0; repeat (10) @(negedge HCLK);
    UART_RX = 1'b1; repeat (10) @(negedge HCLK);
    UART_RX = 1'b0; repeat (10) @(negedge HCLK);
    UART_RX = 1'b1; repeat (10) @(negedge HCLK);
    UART_RX = 1'b0; repeat (5)  @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    UART_RX = 1'b1;
    checks++;
    if (bus.HRDATA !== 32'h0) begin
      $display("FAIL t6_hrdata_reset: got %h expected %h", bus.HRDATA, 32'h0); errors++;
    end
    repeat (20) @(negedge HCLK);
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t6_status_reset: got %h expected %h", d, 32'h0); errors++;
    end
    send_frame(8'h96, 1'b1);
    ahb_read(32'h0, d);
    checks++;
    if (d !== 32'h0000_0096) begin
      $display("FAIL t6_next_frame: got %h expected %h", d, 32'h96); errors++;
    end
    ahb_read(32'h4, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL t6_final_status: got %h expected %h", d, 32'h0); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_overrun();
    test_frame_error();
    test_full_pop_same_edge();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
